// File: rtl/piso_tx_if.sv
// rtl/piso_tx_if.sv - word handshake and serial output bundle for piso_tx
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             q;
  logic             q_valid;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output load,
    input  ready,
    input  q,
    input  q_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output q,
    output q_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with gapless word streaming
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  piso_tx_if.slave  bus
);
  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam int             OUT_BIT = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

  logic             r_q;
  logic             r_q_valid;
  logic             r_busy;
  logic             r_done;

  // Ready is open in IDLE and on the last bit so a new word can follow with no gap
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign w_ready  = (r_state == S_IDLE) || w_last;
  assign w_accept = bus.load && w_ready;

  // Shift toward the output end, zero-filling the vacated position
  assign w_shifted = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);

  // Next-state, next shift register and next bit count
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = bus.din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          // Counter restarts at 0 here, so a non-power-of-2 WIDTH never visits unused codes
          if (w_accept) begin
            w_shreg_nxt = bus.din;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SHIFT;
          end else begin
            w_shreg_nxt = w_shifted;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, shift register and counter; reset discards any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs registered from next-state values so q shows the bit the shift register will present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= 1'b0;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_q       <= (w_state_nxt == S_SHIFT) ? w_shreg_nxt[OUT_BIT] : 1'b0;
      r_q_valid <= (w_state_nxt == S_SHIFT);
      r_busy    <= (w_state_nxt == S_SHIFT);
      r_done    <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == LAST);
    end
  end

  assign bus.ready   = w_ready;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter: accepts a WIDTH-bit word through a ready/load handshake and shifts it out one bit per clock, flagged by `q_valid`. It is the transmit end of the lab's serial bit-stream link. It feeds a serial-in parallel-out receive shift register, which reconstructs the word after WIDTH valid clocks. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 4: word width in bits, legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

- `clk`  input  1  system clock. All state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `din`  input  WIDTH  parallel word, sampled only on an accepted load.
- `load`  input  1  request to transmit `din`.
- `ready`  output  1  combinational; block can accept a word this cycle.
- `q`  output  WIDTH=1  registered serial data out.
- `q_valid`  output  1  registered; `q` carries a payload bit this cycle.
- `busy`  output  1  registered; a word is being shifted out.
- `done`  output  1  registered; one-cycle pulse coincident with the last bit of a word.

## Operation
- Internal state:
  - `shreg[WIDTH-1:0]`;
  - bit counter `cnt`, $clog2(WIDTH) bits;
  - two-state FSM: IDLE and SHIFT.
- Accept condition: `load && ready` at a rising edge. With `load` high and `ready` low, the request is ignored and nothing is queued.
- `ready` = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1).
- IDLE:
  - On accept: `shreg` <= `din`, `cnt` <= 0, state -> SHIFT.
  - Otherwise: `q`=0, `q_valid`=0, `busy`=0.
- SHIFT:
  - Each cycle, `q` presents the current output bit:
    - `shreg[WIDTH-1]` if MSB_FIRST;
    - `shreg[0]` otherwise.
  - At the edge, `shreg` shifts toward the output end, zero-filled, and `cnt` increments.
- Last bit (cnt==WIDTH-1), `done`=1:
  - If accepted at this edge: load the new word, `cnt` <= 0, stay in SHIFT. The output has no gap.
  - Otherwise: state -> IDLE.
- `q`, `q_valid`, `busy` and `done` are driven from registers. `q` is never combinationally dependent on `din`.
- Arithmetic: `cnt` never exceeds WIDTH-1. A non-power-of-2 WIDTH must not wrap through unused codes.

## Timing
- Reset (`rst_n` low, immediately and asynchronously, mid-word included):
  - `q`=0, `q_valid`=0, `busy`=0, `done`=0.
  - `shreg`=0, `cnt`=0, state=IDLE.
  - `ready`=1.
  - Any word in flight is discarded.
- Release: the first accept is possible on the first rising edge with `rst_n` high.
- Latency, word accepted at edge E:
  - Bit k (k=0..WIDTH-1 in send order) is on `q` with `q_valid`=1 during the cycle after edge E+k.
  - The first bit appears one cycle after acceptance.
  - A word occupies exactly WIDTH valid cycles.
- `done` is high during the same cycle as bit WIDTH-1.
- `busy` equals `q_valid`.
- Throughput: one bit per clock. With `load` held high continuously, `q_valid` stays 1 indefinitely.
- `load` asserted in the same cycle `rst_n` deasserts: not accepted, because reset is still active at that edge.
- `din` changing while busy has no effect on the word in flight.

## Test plan
- **Reset:** assert `rst_n`=0 mid-word.
  - Required: outputs go to 0 immediately and `ready`=1.
  - Required: after release, `q_valid` stays 0 until the next accepted load.
- **Single word, MSB_FIRST=1, WIDTH=4:** `din`=4'b1011, `load` for one cycle.
  - Required: `q` = 1,0,1,1 on 4 consecutive `q_valid` cycles starting one cycle later.
  - Required: `done` high only on the 4th bit; then IDLE with `q`=0.
- **Back-to-back:** 4'b1011 accepted, then 4'b0110 presented with `load` high during the last bit.
  - Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0.
  - Required: `done` pulses on bits 4 and 8.
  - Required: no idle cycle between words.
- **Load while busy:** `load`=1 with 4'b1111 during bits 1-3 of a 4'b0001 transfer.
  - Required: output is 0,0,0,1.
  - Required: 4'b1111 is sent only if `load` is still high at the last-bit edge.
- **LSB_FIRST (MSB_FIRST=0):** `din`=4'b1011.
  - Required: `q` = 1,1,0,1.
- **Loopback, WIDTH=8:** send 8'hA5 and 8'h3C back-to-back into a receive shift register enabled by `q_valid`.
  - Required: the receiver holds 8'hA5 after 8 valid cycles and 8'h3C after 16.
